gpio_irq_bank: RTL

- Parametrised memory-mapped GPIO bank for the picorv32/biriscv-style native memory bus. It adds the following over a single fixed 8-bit port:
  - configurable width
  - per-pin direction
  - atomic set and clear of outputs
  - metastability-safe input synchronisation
  - per-pin rising/falling edge interrupts with sticky write-1-to-clear pending bits
- Sits beside the other SoC peripherals on the CPU data bus. gpio_irq feeds the core interrupt input.

---
 rtl/gpio_pkg.sv | 28 ++
 rtl/gpio_irq_bank_if.sv | 23 ++
 rtl/gpio_sync.sv | 29 ++
 rtl/gpio_irq_bank.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO interrupt bank: register offsets, bus FSM
// states and small helpers used by the register file.
package gpio_pkg;

    localparam logic [4:0] OFF_OUT     = 5'h00;
    localparam logic [4:0] OFF_IN      = 5'h04;
    localparam logic [4:0] OFF_DIR     = 5'h08;
    localparam logic [4:0] OFF_OUT_SET = 5'h0C;
    localparam logic [4:0] OFF_OUT_CLR = 5'h10;
    localparam logic [4:0] OFF_RISE_EN = 5'h14;
    localparam logic [4:0] OFF_FALL_EN = 5'h18;
    localparam logic [4:0] OFF_PEND    = 5'h1C;

    typedef enum logic {
        IDLE,
        RESP
    } bus_state_t;

    // The arm counter must reach stages+1, so it needs room for that value.
    function automatic int arm_cnt_width(input int stages);
        return $clog2(stages + 2);
    endfunction

    function automatic logic [31:0] strobe_mask(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_irq_bank_if.sv
// Native memory bus as seen by the GPIO bank: CPU-side request signals and
// the peripheral's select/ready/read-data response.
interface gpio_irq_bank_if;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        gpio_sel;
    logic        gpio_ready;
    logic [31:0] gpio_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  gpio_sel, gpio_ready, gpio_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output gpio_sel, gpio_ready, gpio_rdata
    );

endinterface

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser bringing asynchronous pad inputs into the clk domain.
module gpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_irq_bank.sv
// Memory-mapped GPIO bank with per-pin direction, atomic set/clear of outputs
// and sticky rising/falling edge interrupts.
module gpio_irq_bank #(
    parameter logic [31:0] ADDR        = 32'h8000_0000,
    parameter int          WIDTH       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] OUT_RESET   = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    gpio_irq_bank_if.slave    bus,
    input  logic [WIDTH-1:0]  gpio_pin_in,
    output logic [WIDTH-1:0]  gpio_pin_out,
    output logic [WIDTH-1:0]  gpio_pin_oe,
    output logic              gpio_irq
);

    import gpio_pkg::*;

    localparam int               ARM_W    = arm_cnt_width(SYNC_STAGES);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    bus_state_t       state;
    logic             accept;
    logic             wr;
    logic [4:0]       off;
    logic [31:0]      wmask32;
    logic [31:0]      wbits32;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev_in;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rd_val;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (gpio_pin_in),
        .dout  (sync_in)
    );

    assign bus.gpio_sel = bus.mem_valid
                       && (bus.mem_addr[31:5] == ADDR[31:5])
                       && (bus.mem_addr[1:0] == 2'b00);

    assign accept  = bus.gpio_sel && (state == IDLE);
    assign wr      = accept && (|bus.mem_wstrb);
    assign off     = bus.mem_addr[4:0];
    assign wmask32 = strobe_mask(bus.mem_wstrb);
    assign wbits32 = bus.mem_wdata & wmask32;
    assign wmask   = wmask32[WIDTH-1:0];
    assign wbits   = wbits32[WIDTH-1:0];

    // Bus lanes above the pin count carry nothing this bank can store.
    if (WIDTH < 32) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^{wmask32[31:WIDTH], wbits32[31:WIDTH]};
    end

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_OUT:     rd_val = out_q;
            OFF_IN:      rd_val = sync_in;
            OFF_DIR:     rd_val = dir_q;
            OFF_RISE_EN: rd_val = rise_en_q;
            OFF_FALL_EN: rd_val = fall_en_q;
            OFF_PEND:    rd_val = pend_q;
            default:     rd_val = '0;
        endcase
    end

    // Edges are masked until the synchroniser has flushed its reset zeros.
    assign armed = (arm_cnt == ARM_DONE);
    assign rise  = sync_in & ~prev_in & rise_en_q & {WIDTH{armed}};
    assign fall  = ~sync_in & prev_in & fall_en_q & {WIDTH{armed}};
    assign w1c   = (wr && (off == OFF_PEND)) ? wbits : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bus.gpio_ready <= 1'b0;
            bus.gpio_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.gpio_sel) begin
                        state          <= RESP;
                        bus.gpio_ready <= 1'b1;
                        bus.gpio_rdata <= wr ? 32'h0 : 32'(rd_val);
                    end else begin
                        bus.gpio_ready <= 1'b0;
                        bus.gpio_rdata <= '0;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    bus.gpio_ready <= 1'b0;
                    bus.gpio_rdata <= '0;
                end
                default: begin
                    state          <= IDLE;
                    bus.gpio_ready <= 1'b0;
                    bus.gpio_rdata <= '0;
                end
            endcase
        end
    end

    // Pending bits are OR-ed in after the clear so a coincident edge survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= OUT_RESET[WIDTH-1:0];
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            prev_in   <= '0;
            arm_cnt   <= '0;
        end else begin
            prev_in <= sync_in;
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
            pend_q <= (pend_q & ~w1c) | rise | fall;
            if (wr) begin
                case (off)
                    OFF_OUT:     out_q     <= (out_q & ~wmask) | wbits;
                    OFF_OUT_SET: out_q     <= out_q | wbits;
                    OFF_OUT_CLR: out_q     <= out_q & ~wbits;
                    OFF_DIR:     dir_q     <= (dir_q & ~wmask) | wbits;
                    OFF_RISE_EN: rise_en_q <= (rise_en_q & ~wmask) | wbits;
                    OFF_FALL_EN: fall_en_q <= (fall_en_q & ~wmask) | wbits;
                    default:     ;
                endcase
            end
        end
    end

    assign gpio_pin_out = out_q;
    assign gpio_pin_oe  = dir_q;
    assign gpio_irq     = |pend_q;

endmodule
